// File: rtl/wb_addr_router.sv
// rtl/wb_addr_router.sv - Wishbone single-master to N-slave address router.
// Registered BASE/MASK decode, per-CYC slave lock, decode-miss and watchdog ERR.
module wb_addr_router #(
  parameter int                      N_SLV    = 6,
  parameter int                      ADR_W    = 32,
  parameter int                      DAT_W    = 32,
  parameter logic [N_SLV*ADR_W-1:0]  SLV_BASE = '0,
  parameter logic [N_SLV*ADR_W-1:0]  SLV_MASK = '0,
  parameter int                      TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m_cyc,
  input  logic                     m_stb,
  input  logic                     m_we,
  input  logic [ADR_W-1:0]         m_adr,
  input  logic [DAT_W-1:0]         m_dat_o,
  output logic [DAT_W-1:0]         m_dat_i,
  output logic                     m_ack,
  output logic                     m_err,
  output logic                     m_rty,
  output logic [N_SLV-1:0]         s_cyc,
  output logic [N_SLV-1:0]         s_stb,
  output logic [N_SLV-1:0]         s_we,
  output logic [N_SLV*ADR_W-1:0]   s_adr,
  output logic [N_SLV*DAT_W-1:0]   s_dat_o,
  input  logic [N_SLV*DAT_W-1:0]   s_dat_i,
  input  logic [N_SLV-1:0]         s_ack,
  input  logic [N_SLV-1:0]         s_err,
  input  logic [N_SLV-1:0]         s_rty,
  output logic                     fault,
  output logic [ADR_W-1:0]         fault_adr
);

  localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [ADR_W-1:0]   fault_adr_q, fault_adr_d;

  logic [N_SLV-1:0]   hit;
  logic               dec_found;
  logic [SEL_W-1:0]   dec_idx;
  logic               sel_hit;
  logic               sel_ack;
  logic               sel_err;
  logic               sel_rty;
  logic [DAT_W-1:0]   sel_dat;

  // Window match for every slave; the lowest index wins when windows overlap.
  always_comb begin
    hit       = '0;
    dec_found = 1'b0;
    dec_idx   = '0;
    for (int i = 0; i < N_SLV; i++) begin
      hit[i] = ((m_adr & SLV_MASK[i*ADR_W +: ADR_W]) == SLV_BASE[i*ADR_W +: ADR_W]);
    end
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit[i]) begin
        dec_found = 1'b1;
        dec_idx   = SEL_W'(i);
      end
    end
  end

  assign sel_hit = hit[sel_q];
  assign sel_ack = s_ack[sel_q];
  assign sel_err = s_err[sel_q];
  assign sel_rty = s_rty[sel_q];
  assign sel_dat = s_dat_i[int'(sel_q)*DAT_W +: DAT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      wdog_q      <= '0;
      fault_adr_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      wdog_q      <= wdog_d;
      fault_adr_q <= fault_adr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    wdog_d      = wdog_q;
    fault_adr_d = fault_adr_q;
    s_cyc       = '0;
    s_stb       = '0;
    s_we        = '0;
    s_adr       = '0;
    s_dat_o     = '0;
    m_dat_i     = '0;
    m_ack       = 1'b0;
    m_err       = 1'b0;
    m_rty       = 1'b0;
    fault       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (m_cyc && m_stb) begin
          if (dec_found) begin
            sel_d   = dec_idx;
            state_d = ST_ACTIVE;
          end else begin
            fault_adr_d = m_adr;
            state_d     = ST_FAULT;
          end
        end
      end

      ST_ACTIVE: begin
        if (!m_cyc) begin
          wdog_d  = '0;
          state_d = ST_IDLE;
        end else begin
          s_cyc[sel_q]                       = 1'b1;
          s_we[sel_q]                        = m_we;
          s_adr[int'(sel_q)*ADR_W +: ADR_W]  = m_adr;
          s_dat_o[int'(sel_q)*DAT_W +: DAT_W] = m_dat_o;
          if (m_stb && !sel_hit) begin
            // Beat left the locked slave's window: never strobe it.
            wdog_d      = '0;
            fault_adr_d = m_adr;
            state_d     = ST_FAULT;
          end else begin
            s_stb[sel_q] = m_stb;
            m_ack        = sel_ack;
            m_err        = sel_err;
            m_rty        = sel_rty;
            m_dat_i      = sel_dat;
            if (!m_stb || sel_ack || sel_err || sel_rty) begin
              wdog_d = '0;
            end else if (TIMEOUT != 0 && wdog_q == WD_LAST) begin
              // This stall brings the count to TIMEOUT; a response this cycle would have won.
              wdog_d      = '0;
              fault_adr_d = m_adr;
              state_d     = ST_FAULT;
            end else if (wdog_q != WD_MAX) begin
              wdog_d = wdog_q + 1'b1;
            end
          end
        end
      end

      ST_FAULT: begin
        m_err   = 1'b1;
        fault   = 1'b1;
        wdog_d  = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign fault_adr = fault_adr_q;

endmodule

// File: tb/tb_wb_addr_router.sv
// tb/tb_wb_addr_router.sv - self-checking bench for wb_addr_router.
// Six latency-programmable slave models, vector table, corner sequences and randomized traffic.
module tb_wb_addr_router;

  localparam int N  = 6;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            m_cyc, m_stb, m_we;
  logic [31:0]     m_adr, m_dat_o, m_dat_i;
  logic            m_ack, m_err, m_rty;
  logic [N-1:0]    s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
  logic [N*32-1:0] s_adr, s_dat_o, s_dat_i;
  logic            fault;
  logic [31:0]     fault_adr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_fadr = '0;

  // Slave behaviour: mode 0 ack, 1 err, 2 rty, 3 never answers; answers after lat stalled cycles.
  int lat_cfg [N];
  int mode_cfg[N];
  int scnt    [N];
  logic [N-1:0] resp;

  always #5 clk = ~clk;

  wb_addr_router #(
    .N_SLV   (N),
    .ADR_W   (32),
    .DAT_W   (32),
    .SLV_BASE({32'h5000_0000, 32'h0000_0100, 32'h3000_0000,
               32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLV_MASK({32'hF000_0000, 32'hFFFF_FF00, 32'hF000_0000,
               32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
    .TIMEOUT (TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_o(m_dat_o),
    .m_dat_i(m_dat_i), .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
    .fault(fault), .fault_adr(fault_adr)
  );

  function automatic logic [31:0] key_of(input int i);
    case (i)
      0: return 32'hA5A5_0000;
      1: return 32'h1111_0000;
      2: return 32'hFEAD_BEFF;
      3: return 32'h3333_0000;
      4: return 32'h4444_0000;
      default: return 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int i);
    case (i)
      0: return 32'h0000_0000;
      1: return 32'h1000_0000;
      2: return 32'h2000_0000;
      3: return 32'h3000_0000;
      4: return 32'h0000_0100;
      default: return 32'h5000_0000;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int i);
    return (i == 4) ? 32'hFFFF_FF00 : 32'hF000_0000;
  endfunction

  always_comb begin
    resp    = '0;
    s_ack   = '0;
    s_err   = '0;
    s_rty   = '0;
    s_dat_i = '0;
    for (int i = 0; i < N; i++) begin
      resp[i]  = s_cyc[i] && s_stb[i] && (mode_cfg[i] != 3) && (scnt[i] == lat_cfg[i]);
      s_ack[i] = resp[i] && (mode_cfg[i] == 0);
      s_err[i] = resp[i] && (mode_cfg[i] == 1);
      s_rty[i] = resp[i] && (mode_cfg[i] == 2);
      s_dat_i[i*32 +: 32] = s_adr[i*32 +: 32] ^ key_of(i);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      scnt[i] <= (s_cyc[i] && s_stb[i] && !resp[i]) ? scnt[i] + 1 : 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_all(input int lat, input int mode);
    for (int i = 0; i < N; i++) begin
      lat_cfg[i]  = lat;
      mode_cfg[i] = mode;
    end
  endtask

  // Single-beat transaction; cycle 0 is the cycle the master first presents CYC/STB.
  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                         output int cyc, output int kind, output logic [31:0] rd,
                         output logic [N-1:0] stb_seen, output bit flt_seen, output bit fwd_ok);
    cyc = -1; kind = 0; rd = '0; stb_seen = '0; flt_seen = 0; fwd_ok = 1;
    m_cyc = 1; m_stb = 1; m_we = we; m_adr = adr; m_dat_o = wd;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      stb_seen |= s_stb;
      if (fault) flt_seen = 1;
      for (int i = 0; i < N; i++)
        if (s_stb[i] && (s_adr[i*32 +: 32] !== adr || s_we[i] !== we ||
                         s_dat_o[i*32 +: 32] !== wd || !s_cyc[i]))
          fwd_ok = 0;
      if (m_ack || m_err || m_rty) begin
        cyc  = c;
        kind = int'({m_rty, m_err, m_ack});
        rd   = m_dat_i;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    m_cyc = 0; m_stb = 0; m_we = 0; m_adr = '0; m_dat_o = '0;
    @(posedge clk); #1;
  endtask

  task automatic check_txn(input string tag, input logic [31:0] adr, input logic we,
                           input logic [31:0] wd, input int etgt, input int ekind,
                           input int ecyc, input logic [31:0] edat, input bit eflt);
    int cyc, kind;
    logic [31:0] rd;
    logic [N-1:0] stb_seen;
    bit flt_seen, fwd_ok;
    run_txn(adr, we, wd, cyc, kind, rd, stb_seen, flt_seen, fwd_ok);
    chk({tag, " resp"}, kind, ekind);
    chk({tag, " cycle"}, cyc, ecyc);
    chk({tag, " data"}, rd, edat);
    chk({tag, " strobed"}, {26'd0, stb_seen}, (etgt < 0) ? 32'd0 : (32'd1 << etgt));
    chk({tag, " fault"}, {31'd0, flt_seen}, {31'd0, eflt});
    chk({tag, " fwd"}, {31'd0, fwd_ok}, 32'd1);
    if (eflt) last_fadr = adr;
    chk({tag, " fault_adr"}, fault_adr, last_fadr);
  endtask

  // Reference model: rules of the router expressed per transaction.
  task automatic predict(input logic [31:0] adr, output int tgt, output int kind,
                         output int cyc, output logic [31:0] dat, output bit flt);
    tgt = -1;
    for (int i = 0; i < N; i++) begin
      if ((adr & mask_of(i)) == base_of(i)) begin
        tgt = i;
        break;
      end
    end
    if (tgt < 0) begin
      kind = 2; cyc = 1; dat = '0; flt = 1;
    end else if (mode_cfg[tgt] == 3 || lat_cfg[tgt] >= TO) begin
      kind = 2; cyc = TO + 1; dat = '0; flt = 1;
    end else begin
      kind = 1 << mode_cfg[tgt]; cyc = lat_cfg[tgt] + 1; dat = adr ^ key_of(tgt); flt = 0;
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic        we;
    int          lat;
    int          mode;
    int          tgt;
    int          kind;
    int          cyc;
    logic [31:0] dat;
    bit          flt;
  } vec_t;

  initial begin
    vec_t vt[9];
    int acks, errc, cyc_err;
    logic [31:0] adr;

    vt[0] = '{32'h2000_0010, 1'b0, 0, 0,  2, 1, 1,      32'hDEAD_BEEF, 1'b0};
    vt[1] = '{32'h9000_0000, 1'b1, 0, 0, -1, 2, 1,      32'h0,         1'b1};
    vt[2] = '{32'h3000_0040, 1'b0, 0, 3,  3, 2, TO + 1, 32'h0,         1'b1};
    vt[3] = '{32'h0000_0100, 1'b0, 2, 0,  0, 1, 3,      32'hA5A5_0100, 1'b0};
    vt[4] = '{32'h1000_0004, 1'b1, 7, 0,  1, 1, 8,      32'h0111_0004, 1'b0};
    vt[5] = '{32'h1000_0008, 1'b0, 8, 0,  1, 2, 9,      32'h0,         1'b1};
    vt[6] = '{32'h5000_0000, 1'b0, 1, 1,  5, 2, 2,      32'h0A5A_0000, 1'b0};
    vt[7] = '{32'h4000_0000, 1'b0, 0, 0, -1, 2, 1,      32'h0,         1'b1};
    vt[8] = '{32'h2FFF_FFFC, 1'b1, 3, 2,  2, 4, 4,      32'hD152_4103, 1'b0};

    m_cyc = 0; m_stb = 0; m_we = 0; m_adr = '0; m_dat_o = '0;
    set_all(0, 0);
    #2 rst_n = 0;
    #1;
    chk("rst m_ack", {31'd0, m_ack}, 32'd0);
    chk("rst m_err", {31'd0, m_err}, 32'd0);
    chk("rst m_rty", {31'd0, m_rty}, 32'd0);
    chk("rst m_dat_i", m_dat_i, 32'd0);
    chk("rst s_cyc", {26'd0, s_cyc}, 32'd0);
    chk("rst s_stb", {26'd0, s_stb}, 32'd0);
    chk("rst fault", {31'd0, fault}, 32'd0);
    chk("rst fault_adr", fault_adr, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    for (int k = 0; k < 9; k++) begin
      set_all(vt[k].lat, vt[k].mode);
      check_txn($sformatf("vec%0d", k), vt[k].adr, vt[k].we, 32'hCAFE_0000 + k,
                vt[k].tgt, vt[k].kind, vt[k].cyc, vt[k].dat, vt[k].flt);
    end

    // Burst of four beats to slave1, then a beat outside its window.
    set_all(0, 0);
    acks = 0; errc = 0;
    m_cyc = 1; m_stb = 1; m_we = 0; m_adr = 32'h1000_0000;
    @(negedge clk);
    chk("burst decode bubble", {26'd0, s_stb}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      if (b > 0) m_adr = 32'h1000_0000 + 32'(b * 4);
      @(negedge clk);
      if (m_ack && s_stb == 6'b000010 && m_dat_i == (m_adr ^ 32'h1111_0000)) acks++;
    end
    chk("burst acks", acks, 4);
    @(posedge clk); #1;
    m_adr = 32'h3000_0000;
    @(negedge clk);
    chk("burst miss no strobe", {26'd0, s_stb}, 32'd0);
    chk("burst miss no ack", {31'd0, m_ack}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("burst miss err", {30'd0, fault, m_err}, 32'd3);
    @(posedge clk); #1;
    m_cyc = 0; m_stb = 0; m_adr = '0;
    last_fadr = 32'h3000_0000;
    chk("burst fault_adr", fault_adr, last_fadr);
    @(posedge clk); #1;

    // STB dropped for one cycle restarts the watchdog count.
    set_all(0, 3);
    cyc_err = -1;
    m_cyc = 1; m_adr = 32'h3000_0000;
    for (int c = 0; c < 25; c++) begin
      m_stb = (c != 6);
      @(negedge clk);
      if (m_err) begin
        cyc_err = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("wdog restart cycle", cyc_err, 15);
    @(posedge clk); #1;
    m_cyc = 0; m_stb = 0; m_adr = '0;
    last_fadr = 32'h3000_0000;
    @(posedge clk); #1;

    // Reset while slave5 is strobed.
    m_cyc = 1; m_stb = 1; m_adr = 32'h5000_0000;
    repeat (3) @(negedge clk);
    chk("pre-reset s5 active", {30'd0, s_cyc[5], s_stb[5]}, 32'd3);
    #2 rst_n = 0;
    #1;
    chk("reset drops s_cyc", {26'd0, s_cyc}, 32'd0);
    chk("reset drops s_stb", {26'd0, s_stb}, 32'd0);
    chk("reset no m_err", {31'd0, m_err}, 32'd0);
    m_cyc = 0; m_stb = 0; m_adr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    acks = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (m_ack || m_err || m_rty) acks++;
    end
    chk("post-reset quiet", acks, 0);
    last_fadr = '0;
    chk("post-reset fault_adr", fault_adr, last_fadr);
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    for (int k = 0; k < 80; k++) begin
      int tgt, kind, cyc;
      logic [31:0] dat;
      bit flt;
      logic we;
      for (int i = 0; i < N; i++) begin
        lat_cfg[i]  = $urandom_range(0, 10);
        mode_cfg[i] = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 7) == 0) adr = 32'h0000_0100 | 32'($urandom_range(0, 255));
      else adr = {4'($urandom_range(0, 15)), 28'($urandom)};
      we = 1'($urandom);
      predict(adr, tgt, kind, cyc, dat, flt);
      check_txn($sformatf("rnd%0d", k), adr, we, $urandom, tgt, kind, cyc, dat, flt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
